// File: rtl/serial_link_phy_pkg.sv
// rtl/serial_link_phy_pkg.sv - shared types, constants and config helpers for the multi-channel PHY TX.
package serial_link_phy_pkg;

  // Widest latched config this PHY family supports (MaxClkDiv up to 128, 16 channels).
  localparam int unsigned CfgMaxW = 8;
  localparam int unsigned ChanMax = 16;

  localparam logic [6:0] Prbs7Taps = 7'b110_0000;  // x^7 + x^6 + 1
  localparam logic [6:0] Prbs7Seed = 7'h7F;

  typedef enum logic {
    IDLE,
    ACTIVE
  } phy_tx_state_e;

  typedef struct packed {
    logic [CfgMaxW-1:0] div;
    logic [CfgMaxW-1:0] shift_start;
    logic [CfgMaxW-1:0] shift_end;
    logic               ddr_mode;
    logic [ChanMax-1:0] chan_en;
  } phy_tx_cfg_t;

  function automatic logic [CfgMaxW-1:0] eff_div(input logic [CfgMaxW-1:0] div);
    return (div < CfgMaxW'(2)) ? CfgMaxW'(2) : div;
  endfunction

  function automatic logic cfg_invalid(input phy_tx_cfg_t cfg);
    return (cfg.div < CfgMaxW'(2)) | cfg.div[0] | (cfg.shift_start >= cfg.div) |
           (cfg.shift_end >= cfg.div) | (cfg.shift_start == cfg.shift_end);
  endfunction

endpackage

// File: rtl/serial_link_phy_clkgen.sv
// rtl/serial_link_phy_clkgen.sv - shared bit counter, SDR phase, end-of-word strobe and forwarded clock.
module serial_link_phy_clkgen
  import serial_link_phy_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        active_i,
  input  logic        keep_i,
  input  phy_tx_cfg_t cfg_i,
  output logic        eow_o,
  output logic        first_half_o,
  output logic        half_step_o,
  output logic        clk_o
);

  logic [CfgMaxW-1:0] cnt_q;
  logic [CfgMaxW-1:0] div_eff;
  logic [CfgMaxW-1:0] half;
  logic               phase_q;
  logic               clk_q;
  logic               wrap;
  logic               unused_chan_en;

  assign div_eff        = eff_div(cfg_i.div);
  assign half           = div_eff >> 1;
  assign wrap           = (cnt_q == div_eff - CfgMaxW'(1));
  assign eow_o          = active_i & wrap & (cfg_i.ddr_mode | phase_q);
  assign first_half_o   = cfg_i.ddr_mode ? (cnt_q < half) : ~phase_q;
  assign half_step_o    = active_i & (wrap | (cfg_i.ddr_mode & (cnt_q == half - CfgMaxW'(1))));
  assign clk_o          = clk_q;
  assign unused_chan_en = ^cfg_i.chan_en;

  // Shift points >= div never match because cnt_q never reaches them.
  always_ff @(posedge clk_i) begin
    if (rst_i || !active_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      clk_q   <= 1'b0;
    end else begin
      cnt_q <= wrap ? '0 : cnt_q + CfgMaxW'(1);
      if (eow_o) begin
        phase_q <= 1'b0;
      end else if (wrap) begin
        phase_q <= ~phase_q;
      end
      if (eow_o && !keep_i) begin
        clk_q <= 1'b0;
      end else if ((cnt_q == cfg_i.shift_start) || (cnt_q == cfg_i.shift_end)) begin
        clk_q <= ~clk_q;
      end
    end
  end

endmodule

// File: rtl/serial_link_phy_tx_mc.sv
// rtl/serial_link_phy_tx_mc.sv - multi-channel DDR/SDR PHY transmitter with forwarded clocks.
// Optional PRBS-7 lane pattern generator: define SERIAL_LINK_PHY_TX_PRBS_EN.
module serial_link_phy_tx_mc
  import serial_link_phy_pkg::*;
#(
  parameter  int unsigned NumChannels = 1,
  parameter  int unsigned NumLanes    = 8,
  parameter  int unsigned MaxClkDiv   = 32,
  localparam int unsigned CW          = $clog2(MaxClkDiv) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [CW-1:0]                   clk_div_i,
  input  logic [CW-1:0]                   clk_shift_start_i,
  input  logic [CW-1:0]                   clk_shift_end_i,
  input  logic                            ddr_mode_i,
  input  logic [NumChannels-1:0]          chan_en_i,
  input  logic [NumChannels*2*NumLanes-1:0] data_i,
  input  logic                            valid_i,
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
  input  logic                            prbs_en_i,
`endif
  output logic                            ready_o,
  output logic                            busy_o,
  output logic                            cfg_err_o,
  output logic [NumChannels-1:0]          clk_o,
  output logic [NumChannels*NumLanes-1:0] ddr_o
);

  phy_tx_state_e state_q, state_d;
  phy_tx_cfg_t   cfg_q, cfg_d;
  logic          cfg_err_q;
  logic [NumChannels*2*NumLanes-1:0] data_q;
  logic [NumChannels-1:0][NumLanes-1:0] lane_d, hold_q;
  logic          load, ready, keep, prbs_req, prbs_mode;
  logic          eow, first_half, half_step, clk_q;
  logic          unused_cfg;

  assign unused_cfg = ^cfg_q.chan_en;

  always_comb begin
    cfg_d                         = '0;
    cfg_d.div                     = CfgMaxW'(clk_div_i);
    cfg_d.shift_start             = CfgMaxW'(clk_shift_start_i);
    cfg_d.shift_end               = CfgMaxW'(clk_shift_end_i);
    cfg_d.ddr_mode                = ddr_mode_i;
    cfg_d.chan_en[NumChannels-1:0] = chan_en_i;
  end

`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
  logic                      prbs_q;
  logic [NumLanes-1:0][6:0]  lfsr_q;

  assign prbs_req  = prbs_en_i;
  assign prbs_mode = prbs_q;

  // Generators restart from their seeds whenever the link is idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prbs_q <= 1'b0;
    end else if (state_q == IDLE) begin
      prbs_q <= prbs_en_i;
    end
    for (int l = 0; l < NumLanes; l++) begin
      if (rst_i || state_q == IDLE) begin
        lfsr_q[l] <= Prbs7Seed ^ 7'(l);
      end else if (half_step) begin
        lfsr_q[l] <= {lfsr_q[l][5:0], ^(lfsr_q[l] & Prbs7Taps)};
      end
    end
  end
`else
  assign prbs_req  = 1'b0;
  assign prbs_mode = 1'b0;
`endif

  assign keep = prbs_mode ? prbs_req : valid_i;

  serial_link_phy_clkgen u_clkgen (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .active_i     (state_q == ACTIVE),
    .keep_i       (keep),
    .cfg_i        (cfg_q),
    .eow_o        (eow),
    .first_half_o (first_half),
    .half_step_o  (half_step),
    .clk_o        (clk_q)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready = ~prbs_req;
        if (prbs_req) begin
          state_d = ACTIVE;
        end else if (valid_i) begin
          state_d = ACTIVE;
          load    = 1'b1;
        end
      end
      ACTIVE: begin
        if (eow) begin
          ready = ~prbs_mode;
          if (keep) begin
            load = ~prbs_mode;
          end else begin
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      cfg_err_q <= 1'b0;
      data_q    <= '0;
      hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        data_q <= data_i;
      end
      if (state_q == ACTIVE) begin
        hold_q <= lane_d;
      end
      if (state_q == IDLE) begin
        cfg_q     <= cfg_d;
        cfg_err_q <= cfg_invalid(cfg_d);
      end
    end
  end

  // Lane mux; hold_q keeps the last driven half visible while idle.
  always_comb begin
    lane_d = '0;
    ddr_o  = '0;
    clk_o  = '0;
    for (int c = 0; c < NumChannels; c++) begin
      lane_d[c] = first_half ? data_q[c*2*NumLanes+NumLanes +: NumLanes]
                             : data_q[c*2*NumLanes +: NumLanes];
`ifdef SERIAL_LINK_PHY_TX_PRBS_EN
      if (prbs_mode) begin
        for (int l = 0; l < NumLanes; l++) begin
          lane_d[c][l] = lfsr_q[l][6];
        end
      end
`endif
      if (cfg_q.chan_en[c]) begin
        ddr_o[c*NumLanes +: NumLanes] = (state_q == ACTIVE) ? lane_d[c] : hold_q[c];
        clk_o[c] = clk_q;
      end
    end
  end

  assign ready_o   = ready & ~rst_i;
  assign busy_o    = (state_q != IDLE);
  assign cfg_err_o = cfg_err_q;

endmodule
